// File: rtl/trace_capture.sv
// rtl/trace_capture.sv - passive trace recorder on the core observation bus; optional macro TRACE_TIMESTAMP_EN adds out_time
module trace_capture #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       pc,
    input  logic [31:0]       instr,
    input  logic [31:0]       result,
    input  logic [3:0]        flags,
    input  logic              arm,
    input  logic              trig_pc_en,
    input  logic [31:0]       trig_pc,
    input  logic              stop,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_pc,
    output logic [31:0]       out_instr,
    output logic [31:0]       out_result,
    output logic [3:0]        out_flags,
    output logic [AW:0]       count,
    output logic [1:0]        state,
    output logic              overflow
`ifdef TRACE_TIMESTAMP_EN
    ,
    output logic [31:0]       out_time
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

    typedef struct packed {
`ifdef TRACE_TIMESTAMP_EN
        logic [31:0] ts;
`endif
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] result;
        logic [3:0]  flags;
    } entry_t;

    localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE    = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);

    state_e        state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          first_q, first_d;
    logic [31:0]   last_pc_q, last_pc_d;
    entry_t        hold_q, hold_d;
`ifdef TRACE_TIMESTAMP_EN
    logic [31:0]   time_q, time_d;
`endif

    entry_t        mem_q [DEPTH];
    entry_t        wr_entry;
    entry_t        head;

    logic          is_empty;
    logic          is_full;
    logic          pop;
    logic          cap_event;
    logic          trig_hit;
    logic          want_push;
    logic          push;
    logic          drop;

    // Capture/pop qualification; arm overrides everything, and a stop cycle records nothing
    always_comb begin
        is_empty  = (count_q == '0);
        is_full   = (count_q == FULL_COUNT);
        pop       = !is_empty && out_ready && !arm;
        cap_event = (state_q == ST_CAPTURE) && !arm && !stop &&
                    (first_q || (pc != last_pc_q));
        trig_hit  = (state_q == ST_ARMED) && !arm && (pc == trig_pc);
        want_push = cap_event || trig_hit;
        // a pop in the same cycle frees the slot, so a full FIFO can still accept
        push      = want_push && (!is_full || pop);
        drop      = want_push && is_full && !pop;
    end

    // Entry assembled from the live bus on the capture cycle
    always_comb begin
        wr_entry        = '0;
        wr_entry.pc     = pc;
        wr_entry.instr  = instr;
        wr_entry.result = result;
        wr_entry.flags  = flags;
`ifdef TRACE_TIMESTAMP_EN
        wr_entry.ts     = time_q;
`endif
    end

    // Head view: live slot while non-empty, otherwise the last value that was shown
    always_comb begin
        head   = is_empty ? hold_q : mem_q[rd_ptr_q];
        hold_d = head;
    end

    // Session control: state, first-cycle flag and sticky overflow
    always_comb begin
        state_d    = state_q;
        first_d    = first_q;
        overflow_d = overflow_q;
        if (arm) begin
            state_d    = trig_pc_en ? ST_ARMED : ST_CAPTURE;
            first_d    = 1'b1;
            overflow_d = 1'b0;
        end else begin
            case (state_q)
                ST_ARMED: begin
                    if (trig_hit) begin
                        state_d = drop ? ST_DONE : ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    if (stop || drop) begin
                        state_d = ST_DONE;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
            if (want_push) begin
                first_d = 1'b0;
            end
            if (drop) begin
                overflow_d = 1'b1;
            end
        end
    end

    // FIFO pointer and occupancy bookkeeping; arm flushes
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (arm) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            if (push && !pop) begin
                count_d = count_q + CNT_ONE;
            end else if (pop && !push) begin
                count_d = count_q - CNT_ONE;
            end
        end
    end

    // Previous-PC tracker used for change detection, updated every cycle
    always_comb begin
        last_pc_d = pc;
    end

`ifdef TRACE_TIMESTAMP_EN
    // Free-running cycle counter, restarted by arm
    always_comb begin
        time_d = arm ? 32'd0 : (time_q + 32'd1);
    end
`endif

    // State registers with asynchronous clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            first_q    <= 1'b1;
            last_pc_q  <= '0;
            hold_q     <= '0;
`ifdef TRACE_TIMESTAMP_EN
            time_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            first_q    <= first_d;
            last_pc_q  <= last_pc_d;
            hold_q     <= hold_d;
`ifdef TRACE_TIMESTAMP_EN
            time_q     <= time_d;
`endif
        end
    end

    // Entry storage; contents are only observed through count-qualified reads
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_entry;
        end
    end

    assign out_valid  = !is_empty;
    assign out_pc     = head.pc;
    assign out_instr  = head.instr;
    assign out_result = head.result;
    assign out_flags  = head.flags;
    assign count      = count_q;
    assign state      = state_q;
    assign overflow   = overflow_q;
`ifdef TRACE_TIMESTAMP_EN
    assign out_time   = head.ts;
`endif

endmodule

// File: doc/trace_capture.md
Name: trace_capture

Overview:
Passive reader on the RV32I core's debug/observation bus (pc, instr, result, flags). It watches the bus from the same side a testbench does and records one entry per retired-PC change into an on-chip FIFO. Capture starts on an arm pulse with an optional PC-match trigger, and stops on command or when the FIFO is full. Entries are drained by a downstream consumer (UART dumper, JTAG-style reader) over a valid/ready handshake.

Parameters:
DEPTH, 16, FIFO entries; power of two, minimum 2.
AW, 4, log2(DEPTH); pointer width.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high; clears all state.
pc  in  32  core current PC.
instr  in  32  core current instruction.
result  in  32  core writeback result.
flags  in  4  core ALU flags.
arm  in  1  single-cycle pulse; flush FIFO and start a capture session.
trig_pc_en  in  1  1 = wait for trig_pc match before capturing.
trig_pc  in  32  trigger PC.
stop  in  1  single-cycle pulse; end capture.
out_valid  out  1  FIFO non-empty.
out_ready  in  1  consumer accepts the head entry.
out_pc, out_instr, out_result  out  32 each  head entry fields.
out_flags  out  4  head entry flags.
count  out  AW+1  number of entries held, 0..DEPTH.
state  out  2  0 IDLE, 1 ARMED, 2 CAPTURE, 3 DONE.
overflow  out  1  sticky; a capture event was dropped.

Behaviour:
- Reset (async): state=IDLE, FIFO empty, count=0, out_valid=0, out_* data=0, overflow=0, last_pc=0, first=1.
- Capture event in CAPTURE: first cycle in CAPTURE, or pc != last_pc (registered). Stalls, where pc is held, produce no entry. last_pc updates every cycle.
- FSM:
  - IDLE/DONE --arm--> ARMED if trig_pc_en=1, otherwise CAPTURE.
  - ARMED: when pc==trig_pc, capture that cycle's bus values and move to CAPTURE (first=0).
  - CAPTURE --stop--> DONE. stop ignored in IDLE/ARMED/DONE.
  - CAPTURE, event while full with no pop: entry dropped, overflow=1, move to DONE.
- arm in any state: flush FIFO (pointers and count=0), clear overflow, set first=1, enter ARMED/CAPTURE. arm has priority over stop, push and pop in the same cycle.
- Push: bus sampled on the event cycle. Entry is visible on out_* and count increments at the next clock edge (latency 1).
- Pop: when out_valid & out_ready; allowed in every state. out_* show the new head after the edge. out_* are combinational from mem[rd_ptr] and hold the last value when empty.
- Push and pop in the same cycle: both happen and count is unchanged. When full, the push is accepted because the pop frees the slot, so no overflow.
- Pointers wrap modulo DEPTH. Full = count==DEPTH. Empty = count==0.
- out_valid must not depend combinationally on out_ready.

Optional Feature:
TRACE_TIMESTAMP_EN.
- Defined: adds port out_time (out, 32) and a free-running cycle counter. The counter clears on reset and on arm, and wraps at 2^32. Each entry stores the counter value at its capture cycle, and out_time shows the head entry's value.
- Undefined: no counter, no out_time port, no timestamp storage.

Test Plan:
- Reset mid-session (after 5 captures): assert reset asynchronously between edges -> immediately state=0, count=0, out_valid=0, overflow=0.
- arm with trig_pc_en=0, out_ready=0, pc stepping 0x0,0x4,0x8,0x8,0xC -> 4 entries (0x8 stall recorded once), count=4, head out_pc=0x0, state=2.
- trig_pc_en=1, trig_pc=0x10, pc stepping 0x0..0x1C by 4 -> state=1 until pc=0x10, then entries 0x10,0x14,0x18,0x1C.
- DEPTH=16, out_ready=0, 17 distinct PCs -> count=16, overflow=1, state=3, and the 17th PC is absent. Then out_ready=1 -> 16 pops in order, out_valid=0 after the last.
- Full FIFO in CAPTURE with out_ready=1 and a new PC in the same cycle -> count stays 16, overflow stays 0, head advances by one.
- stop then arm in one cycle, with arm and stop asserted together while 3 entries are held -> FIFO flushed (count=0), session restarts. With TRACE_TIMESTAMP_EN, the first entry after arm has out_time=0.
